// File: rtl/controlador_restador_if.sv
// Requester-side bundle for the shared subtractor: two request/grant channels
// with per-requester operands and buffered result handshakes.
interface controlador_restador_if;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic       gnt0, gnt1;
    logic       rsp_valid0, rsp_valid1;
    logic       rsp_ready0, rsp_ready1;
    logic [3:0] y0, y1;
    logic [3:0] flags0, flags1;

    modport master (
        output req0, req1, a0, b0, a1, b1, rsp_ready0, rsp_ready1,
        input  gnt0, gnt1, rsp_valid0, rsp_valid1, y0, y1, flags0, flags1
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, rsp_ready0, rsp_ready1,
        output gnt0, gnt1, rsp_valid0, rsp_valid1, y0, y1, flags0, flags1
    );
endinterface

// File: rtl/controlador_restador.sv
// Two-requester round-robin arbiter around one 4-bit subtractor (A - B) with
// a per-requester result buffer carrying Y and {N,Z,C,V}.
module controlador_restador (
    input  logic                   clk,
    input  logic                   rst_n,
    controlador_restador_if.slave  bus,
    output logic                   busy,
    output logic [7:0]             op_count
);
    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t     state;
    logic       last1;      // 1: requester 1 was granted most recently
    logic       owner;
    logic [3:0] lat_a, lat_b;
    logic       rv0, rv1;
    logic [3:0] y0_q, y1_q, f0_q, f1_q;

    logic       elig0, elig1, pick0, pick1;
    logic [4:0] sum;
    logic [3:0] diff;
    logic [3:0] flags;

    // A buffer whose result is being consumed this edge can accept a new grant.
    assign elig0 = bus.req0 & (~rv0 | bus.rsp_ready0);
    assign elig1 = bus.req1 & (~rv1 | bus.rsp_ready1);
    assign pick1 = (state == IDLE) & elig1 & (~elig0 | ~last1);
    assign pick0 = (state == IDLE) & elig0 & ~pick1;

    // Grant is decided in the same cycle as eligibility, so it is gated by reset.
    assign bus.gnt0 = rst_n & pick0;
    assign bus.gnt1 = rst_n & pick1;

    assign sum  = {1'b0, lat_a} + {1'b0, ~lat_b} + 5'd1;
    assign diff = sum[3:0];
    assign flags = {diff[3],
                    (diff == 4'd0),
                    ~sum[4],
                    (lat_a[3] & ~lat_b[3] & ~diff[3]) | (~lat_a[3] & lat_b[3] & diff[3])};

    assign busy           = (state == EXEC);
    assign bus.rsp_valid0 = rv0;
    assign bus.rsp_valid1 = rv1;
    assign bus.y0         = y0_q;
    assign bus.y1         = y1_q;
    assign bus.flags0     = f0_q;
    assign bus.flags1     = f1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last1    <= 1'b1;
            owner    <= 1'b0;
            lat_a    <= '0;
            lat_b    <= '0;
            rv0      <= 1'b0;
            rv1      <= 1'b0;
            y0_q     <= '0;
            y1_q     <= '0;
            f0_q     <= '0;
            f1_q     <= '0;
            op_count <= '0;
        end else begin
            if (rv0 && bus.rsp_ready0) rv0 <= 1'b0;
            if (rv1 && bus.rsp_ready1) rv1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick0 || pick1) begin
                        lat_a <= pick1 ? bus.a1 : bus.a0;
                        lat_b <= pick1 ? bus.b1 : bus.b0;
                        owner <= pick1;
                        last1 <= pick1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // NOTE: with non-blocking assignments the later write in this
                    // block wins, so a result write overrides a same-edge consume.
                    if (owner) begin
                        y1_q <= diff;
                        f1_q <= flags;
                        rv1  <= 1'b1;
                    end else begin
                        y0_q <= diff;
                        f0_q <= flags;
                        rv0  <= 1'b1;
                    end
                    op_count <= op_count + 8'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/controlador_restador.md
CONTROLADOR_RESTADOR -- requirements
Module: controlador_restador

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 req0, req1  input  1 each  requester k asks for one subtraction; held until gnt_k.
REQ-004 a0, b0, a1, b1  input  4 each  operands of requester k (A minus B); sampled only in the grant cycle.
REQ-005 gnt0, gnt1  output  1 each  one-cycle pulse, operands of requester k captured this edge.
REQ-006 rsp_valid0, rsp_valid1  output  1 each  result buffer k holds an undelivered result.
REQ-007 rsp_ready0, rsp_ready1  input  1 each  requester k consumes its result when rsp_valid_k high.
REQ-008 y0, y1  output  4 each  registered difference for requester k.
REQ-009 flags0, flags1  output  4 each  registered {N,Z,C,V} for requester k.
REQ-010 busy  output  1  high in state EXEC.
REQ-011 op_count  output  8  completed operations, wraps 255->0.

Function
REQ-012 One internal 4-bit subtractor; shared by both requesters; computes A + ~B + 1 on latched operands.
REQ-013 Y = low 4 bits of sum; Z = (Y==0); N = Y[3]; C = borrow = NOT carry-out (1 iff A<B unsigned); V = (A3 & ~B3 & ~Y3) | (~A3 & B3 & Y3).
REQ-014 FSM states IDLE, EXEC; reset state IDLE.
REQ-015 Requester k eligible in IDLE iff req_k & (~rsp_valid_k | rsp_ready_k).
REQ-016 IDLE, no eligible requester: stay IDLE, no gnt.
REQ-017 IDLE, one eligible: assert its gnt for that cycle, latch its a/b and owner id, go EXEC.
REQ-018 IDLE, both eligible: grant the requester not granted last (round-robin pointer); pointer updates to grantee.
REQ-019 EXEC: write Y/flags into owner's buffer, set rsp_valid_owner, increment op_count, return to IDLE; never stalls.
REQ-020 Latency: gnt edge to rsp_valid high = 2 edges; throughput max one operation per 2 cycles.
REQ-021 gnt0 and gnt1 never high together; no gnt in EXEC.
REQ-022 rsp_valid_k clears on edge where rsp_valid_k & rsp_ready_k, unless the EXEC write targets k on that edge (write wins, valid stays 1).
REQ-023 Buffer k contents stable while rsp_valid_k high and not consumed; non-owner buffer unaffected by EXEC.
REQ-024 rsp_ready_k with rsp_valid_k low: no effect.
REQ-025 req_k dropped before gnt: no operation, no error.

Reset
REQ-026 rst_n low: immediately state IDLE, gnt0/1=0, rsp_valid0/1=0, y0/y1=0, flags0/1=0, busy=0, op_count=0, round-robin pointer = requester 1 last (requester 0 wins first tie).
REQ-027 Reset asserted during EXEC: in-flight operation discarded; no result delivered after release.
REQ-028 First edge after release samples in IDLE with all state from REQ-026.

Verification
REQ-029 req0, a0=5, b0=3 -> gnt0 pulse, 2 edges later rsp_valid0=1, y0=0010, flags0={0,0,0,0}, op_count=1.
REQ-030 req1, a1=3, b1=5 -> y1=1110, flags1={1,0,1,0}; a1=7, b1=15 -> y1=1000, flags1={1,0,1,1}; a1=8, b1=1 -> y1=0111, flags1={0,0,0,1}; a1=4, b1=4 -> y1=0000, flags1={0,1,0,0}.
REQ-031 req0 and req1 high continuously, ready both high, from reset -> grants alternate gnt0, gnt1, gnt0, ... one every 2 cycles; never simultaneous.
REQ-032 rsp_valid0=1, rsp_ready0=0, req0 high -> no gnt0; req1 still served; raising rsp_ready0 -> gnt0 same cycle, old y0 held until consumed.
REQ-033 rst_n pulsed low in EXEC cycle -> all outputs zero asynchronously; no rsp_valid afterward; op_count=0.
REQ-034 256 completed operations -> op_count wraps to 0.
